spart_tx_sched: RTL and testbench

Transmit scheduler that sits between the CPU MEM-stage store port and the SPART transmitter. It decodes CPU stores that hit the SPART register window and queues them in a small FIFO. It serializes each queued entry into bytes over a valid/ready handshake, and raises a stall to the hazard unit when the queue cannot accept a store.

---
 rtl/spart_pkg.sv | 20 ++
 rtl/spart_tx_sched_if.sv | 21 ++
 rtl/spart_tx_fifo.sv | 63 ++++++
 rtl/spart_tx_sched.sv | 131 +++++++++++++
 tb/tb_spart_tx_sched.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART transmit scheduler:
// FSM state encoding, register-window offsets and the default window base.
package spart_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  localparam logic [1:0]  OFF_TXWORD         = 2'd0;
  localparam logic [1:0]  OFF_TXBYTE         = 2'd1;
  localparam logic [31:0] SPART_BASE_DEFAULT = 32'h0000_C000;
  localparam int          ENTRY_W            = 33;

  // Number of bytes a queued entry expands into on the wire.
  function automatic logic [2:0] byte_count(input logic single);
    return single ? 3'd1 : 3'd4;
  endfunction

endpackage

// File: rtl/spart_tx_sched_if.sv
// CPU store port plus SPART byte handshake for the transmit scheduler.
// master: the CPU/SPART environment; slave: the scheduler.
interface spart_tx_sched_if;
  logic        wrt_en;
  logic [31:0] wrt_add;
  logic [31:0] wrt_data;
  logic        stall;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output wrt_en, wrt_add, wrt_data, tx_ready,
    input  stall, tx_valid, tx_data
  );

  modport slave (
    input  wrt_en, wrt_add, wrt_data, tx_ready,
    output stall, tx_valid, tx_data
  );
endinterface

// File: rtl/spart_tx_fifo.sv
// Synchronous FIFO holding {single, data} store entries. The head entry is
// visible combinationally on rdata; push on full and pop on empty are ignored.
module spart_tx_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 33,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
  localparam logic [AW:0]   LVL_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (level_r == LVL_MAX);
  assign empty     = (level_r == (AW+1)'(0));
  assign level     = level_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage array: written at the tail on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally; occupancy holds when push and pop coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/spart_tx_sched.sv
// SPART transmit scheduler: decodes CPU stores into the SPART window, queues
// them, and serializes each entry LSB-first over a valid/ready byte handshake.
// Optional feature macro: SPART_TX_STATS_EN adds a saturating tx_cnt output.
module spart_tx_sched
  import spart_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] SPART_BASE = SPART_BASE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  spart_tx_sched_if.slave        bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
`ifdef SPART_TX_STATS_EN
  ,
  output logic [15:0]            tx_cnt
`endif
);

  logic              hit_s;
  logic              off_ok_s;
  logic              single_s;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic              xfer_s;
  logic              last_s;
  logic              unused_s;
  logic [ENTRY_W-1:0] entry_s;
  logic [ENTRY_W-1:0] head_s;
  tx_state_e         state_r;
  tx_state_e         state_nxt_s;
  logic [31:0]       sh_r;
  logic [2:0]        cnt_r;

  // Store decode: only TXWORD/TXBYTE offsets inside the window are queued.
  assign hit_s    = bus.wrt_en && (bus.wrt_add[31:4] == SPART_BASE[31:4]);
  assign off_ok_s = (bus.wrt_add[3:2] == OFF_TXWORD) || (bus.wrt_add[3:2] == OFF_TXBYTE);
  assign single_s = (bus.wrt_add[3:2] == OFF_TXBYTE);
  assign entry_s  = single_s ? {1'b1, 24'h00_0000, bus.wrt_data[7:0]} : {1'b0, bus.wrt_data};
  assign push_s   = hit_s && off_ok_s && !full_s;
  // Conservative: a pop in the same cycle does not release the stall.
  assign bus.stall = hit_s && off_ok_s && full_s;
  assign unused_s = ^bus.wrt_add[1:0];

  assign xfer_s = (state_r == SEND) && bus.tx_ready;
  assign last_s = xfer_s && (cnt_r == 3'd1);

  assign bus.tx_valid = (state_r == SEND);
  assign bus.tx_data  = sh_r[7:0];
  assign busy         = (state_r == SEND) || !empty_s;

  spart_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .wdata (entry_s),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next state: leave SEND only when the last byte goes with nothing queued.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!empty_s) state_nxt_s = SEND;
        else          state_nxt_s = IDLE;
      end
      SEND: begin
        if (last_s && empty_s) state_nxt_s = IDLE;
        else                   state_nxt_s = SEND;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: pop when idle with work, or on the last byte for a gapless chain.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      IDLE:    pop_s = !empty_s;
      SEND:    pop_s = last_s && !empty_s;
      default: pop_s = 1'b0;
    endcase
  end

  // Shift register and byte counter; bytes leave from sh_r[7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_r  <= 32'h0000_0000;
      cnt_r <= 3'd0;
    end else if (pop_s) begin
      sh_r  <= head_s[31:0];
      cnt_r <= byte_count(head_s[32]);
    end else if (last_s) begin
      sh_r  <= 32'h0000_0000;
      cnt_r <= 3'd0;
    end else if (xfer_s) begin
      sh_r  <= {8'h00, sh_r[31:8]};
      cnt_r <= cnt_r - 3'd1;
    end else begin
      sh_r  <= sh_r;
      cnt_r <= cnt_r;
    end
  end

`ifdef SPART_TX_STATS_EN
  // Saturating count of accepted bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            tx_cnt <= 16'h0000;
    else if (xfer_s && tx_cnt != 16'hFFFF) tx_cnt <= tx_cnt + 16'h0001;
    else                                   tx_cnt <= tx_cnt;
  end
`endif

endmodule

// File: tb/tb_spart_tx_sched.sv
// Directed bench for spart_tx_sched with hand-computed expectations.
// Define SPART_TX_STATS_EN to also check the tx_cnt statistics output.
module tb_spart_tx_sched;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [2:0] level;
`ifdef SPART_TX_STATS_EN
  logic [15:0] tx_cnt;
`endif
  int tests;
  int fails;

  spart_tx_sched_if bus ();

  spart_tx_sched #(
    .DEPTH      (4),
    .SPART_BASE (32'h0000_C000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy),
    .level (level)
`ifdef SPART_TX_STATS_EN
    ,
    .tx_cnt (tx_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d);
    bus.wrt_en   = 1'b1;
    bus.wrt_add  = a;
    bus.wrt_data = d;
  endtask

  task automatic idle_bus();
    bus.wrt_en   = 1'b0;
    bus.wrt_add  = 32'h0000_0000;
    bus.wrt_data = 32'h0000_0000;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    idle_bus();
    bus.tx_ready = 1'b1;

    // Reset state
    #12;
    check("rst_stall",    32'(bus.stall),    32'h0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    check("rst_tx_data",  32'(bus.tx_data),  32'h0);
    check("rst_busy",     32'(busy),         32'h0);
    check("rst_level",    32'(level),        32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset mid-SEND, with a second word queued behind the first
    put(32'h0000_C000, 32'hA1B2_C3D4);
    tick();
    check("rms_level1", 32'(level), 32'h1);
    put(32'h0000_C000, 32'h5566_7788);
    tick();
    idle_bus();
    check("rms_valid",  32'(bus.tx_valid), 32'h1);
    check("rms_byte0",  32'(bus.tx_data),  32'hD4);
    check("rms_queued", 32'(level),        32'h1);
    tick();
    check("rms_byte1", 32'(bus.tx_data), 32'hC3);
    tick();
    check("rms_byte2", 32'(bus.tx_data), 32'hB2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rms_valid_drop", 32'(bus.tx_valid), 32'h0);
    check("rms_level_clr",  32'(level),        32'h0);
    check("rms_busy_clr",   32'(busy),         32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rms_no_more", 32'(bus.tx_valid), 32'h0);
    end

    // Back-to-back drain: two words, 8 contiguous bytes
    put(32'h0000_C000, 32'h0403_0201);
    tick();
    put(32'h0000_C000, 32'h0807_0605);
    tick();
    idle_bus();
    for (int i = 0; i < 8; i++) begin
      check("b2b_valid", 32'(bus.tx_valid), 32'h1);
      check("b2b_data",  32'(bus.tx_data),  32'(i + 1));
      tick();
    end
    check("b2b_end_valid", 32'(bus.tx_valid), 32'h0);
    check("b2b_end_busy",  32'(busy),         32'h0);
`ifdef SPART_TX_STATS_EN
    check("b2b_tx_cnt", 32'(tx_cnt), 32'h8);
`endif

    // Single word: latency 2 edges, bytes LSB first
    put(32'h0000_C000, 32'h4433_2211);
    tick();
    idle_bus();
    check("sw_valid_n1", 32'(bus.tx_valid), 32'h0);
    check("sw_level_n1", 32'(level),        32'h1);
    check("sw_busy_n1",  32'(busy),         32'h1);
    tick();
    check("sw_valid_n2", 32'(bus.tx_valid), 32'h1);
    check("sw_b0", 32'(bus.tx_data), 32'h11);
    tick();
    check("sw_b1", 32'(bus.tx_data), 32'h22);
    tick();
    check("sw_b2", 32'(bus.tx_data), 32'h33);
    tick();
    check("sw_b3", 32'(bus.tx_data), 32'h44);
    check("sw_busy_last", 32'(busy), 32'h1);
    tick();
    check("sw_valid_end", 32'(bus.tx_valid), 32'h0);
    check("sw_busy_end",  32'(busy),         32'h0);

    // TXBYTE sends exactly one byte
    put(32'h0000_C004, 32'hFFFF_FF41);
    tick();
    idle_bus();
    check("tb_level", 32'(level), 32'h1);
    tick();
    check("tb_valid", 32'(bus.tx_valid), 32'h1);
    check("tb_data",  32'(bus.tx_data),  32'h41);
    tick();
    check("tb_valid_end", 32'(bus.tx_valid), 32'h0);
    check("tb_level_end", 32'(level),        32'h0);

    // Reserved offset 8 is ignored
    put(32'h0000_C008, 32'h1234_5678);
    #1;
    check("off8_stall", 32'(bus.stall), 32'h0);
    tick();
    idle_bus();
    check("off8_level", 32'(level), 32'h0);
    tick();
    check("off8_valid", 32'(bus.tx_valid), 32'h0);

    // Backpressure: byte held for 5 cycles, then completes in order
    bus.tx_ready = 1'b0;
    put(32'h0000_C000, 32'h4433_2211);
    tick();
    idle_bus();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 32'(bus.tx_valid), 32'h1);
      check("bp_hold_data",  32'(bus.tx_data),  32'h11);
      tick();
    end
    bus.tx_ready = 1'b1;
    tick();
    check("bp_b1", 32'(bus.tx_data), 32'h22);
    tick();
    check("bp_b2", 32'(bus.tx_data), 32'h33);
    tick();
    check("bp_b3", 32'(bus.tx_data), 32'h44);
    tick();
    check("bp_end_valid", 32'(bus.tx_valid), 32'h0);
    check("bp_end_level", 32'(level),        32'h0);

    // Full/stall: first byte moves into the shift register, four more fill the FIFO
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      put(32'h0000_C004, 32'h50 + 32'(i));
      #1;
      check("fs_no_stall", 32'(bus.stall), 32'h0);
      tick();
    end
    idle_bus();
    check("fs_level_full", 32'(level),       32'h4);
    check("fs_head_byte",  32'(bus.tx_data), 32'h51);
    put(32'h0000_C004, 32'h0000_0056);
    #1;
    check("fs_stall", 32'(bus.stall), 32'h1);
    bus.tx_ready = 1'b1;
    tick();
    check("fs_level_a", 32'(level),       32'h3);
    check("fs_stall_a", 32'(bus.stall),   32'h0);
    check("fs_byte_a",  32'(bus.tx_data), 32'h52);
    tick();
    idle_bus();
    check("fs_level_b", 32'(level),       32'h3);
    check("fs_byte_b",  32'(bus.tx_data), 32'h53);
    tick();
    check("fs_byte_c", 32'(bus.tx_data), 32'h54);
    tick();
    check("fs_byte_d", 32'(bus.tx_data), 32'h55);
    tick();
    check("fs_byte_e",  32'(bus.tx_data), 32'h56);
    check("fs_level_e", 32'(level),       32'h0);
    tick();
    check("fs_end_valid", 32'(bus.tx_valid), 32'h0);
    check("fs_end_busy",  32'(busy),         32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
